// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: opcodes, the hazard FSM state type and
// helpers that tell which source registers an instruction reads.
package cpu_pkg;

    localparam logic [6:0] OP_R       = 7'b0110011;
    localparam logic [6:0] OP_I       = 7'b0010011;
    localparam logic [6:0] OP_LW      = 7'b0000011;
    localparam logic [6:0] OP_S       = 7'b0100011;
    localparam logic [6:0] OP_SB      = 7'b1100011;
    localparam logic [6:0] FUNCT7_MUL = 7'b0000001;

    typedef enum logic {
        RUN = 1'b0,
        MUL = 1'b1
    } state_e;

    function automatic logic uses_rs1(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LW) ||
               (op == OP_S) || (op == OP_SB);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_S) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle between the pipeline datapath (master) and the hazard unit (slave).
interface hazard_unit_if #(
    parameter int CNT_W = 16
);
    logic [6:0]       id_opcode;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             ex_is_mult;
    logic             branch_taken;
    logic             clr_stats;

    logic             ctrl_src;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_write;
    logic             ex_mem_bubble;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_opcode, id_rs1, id_rs2, ex_mem_read, ex_rd,
               ex_is_mult, branch_taken, clr_stats,
        input  ctrl_src, pc_write, if_id_write, if_id_flush,
               id_ex_write, ex_mem_bubble, stall_cycles, flush_count
    );

    modport slave (
        input  id_opcode, id_rs1, id_rs2, ex_mem_read, ex_rd,
               ex_is_mult, branch_taken, clr_stats,
        output ctrl_src, pc_write, if_id_write, if_id_flush,
               id_ex_write, ex_mem_bubble, stall_cycles, flush_count
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that beats the increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and
// multi-cycle multiply stalls, with saturating stall/flush statistics.
module hazard_unit
    import cpu_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_unit_if.slave hif
);

    localparam logic [3:0] MUL_RELOAD = 4'(MUL_CYCLES - 2);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       load_use;
    logic       flush_evt;
    logic       stall_evt;

    assign load_use = hif.ex_mem_read && (hif.ex_rd != 5'd0) &&
                      ((uses_rs1(hif.id_opcode) && (hif.ex_rd == hif.id_rs1)) ||
                       (uses_rs2(hif.id_opcode) && (hif.ex_rd == hif.id_rs2)));

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        flush_evt         = 1'b0;
        hif.ctrl_src      = 1'b0;
        hif.pc_write      = 1'b1;
        hif.if_id_write   = 1'b1;
        hif.if_id_flush   = 1'b0;
        hif.id_ex_write   = 1'b1;
        hif.ex_mem_bubble = 1'b0;

        if (!rst_n) begin
            hif.ctrl_src      = 1'b1;
            hif.if_id_flush   = 1'b1;
            hif.ex_mem_bubble = 1'b1;
            hif.pc_write      = 1'b0;
            hif.if_id_write   = 1'b0;
            hif.id_ex_write   = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hif.ex_is_mult) begin
                        hif.pc_write      = 1'b0;
                        hif.if_id_write   = 1'b0;
                        hif.id_ex_write   = 1'b0;
                        hif.ex_mem_bubble = 1'b1;
                        cnt_d             = MUL_RELOAD;
                        state_d           = MUL;
                    end else if (hif.branch_taken) begin
                        // The ID instruction is squashed, so any load-use on it is moot.
                        hif.if_id_flush = 1'b1;
                        hif.ctrl_src    = 1'b1;
                        flush_evt       = 1'b1;
                    end else if (load_use) begin
                        hif.pc_write    = 1'b0;
                        hif.if_id_write = 1'b0;
                        hif.ctrl_src    = 1'b1;
                    end
                end
                MUL: begin
                    if (cnt_q != 4'd0) begin
                        hif.pc_write      = 1'b0;
                        hif.if_id_write   = 1'b0;
                        hif.id_ex_write   = 1'b0;
                        hif.ex_mem_bubble = 1'b1;
                        cnt_d             = cnt_q - 4'd1;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_evt = rst_n && !hif.pc_write;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (stall_evt),
        .clr_i   (hif.clr_stats),
        .count_o (hif.stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (flush_evt),
        .clr_i   (hif.clr_stats),
        .count_o (hif.flush_count)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios then random traffic
// compared against a cycle-level behavioural model.
module tb_hazard_unit;

    localparam int CW   = 8;
    localparam int MULC = 4;
    localparam int CMAX = (1 << CW) - 1;

    // {ctrl_src, pc_write, if_id_write, if_id_flush, id_ex_write, ex_mem_bubble}
    localparam logic [5:0] F_RST = 6'b100101;
    localparam logic [5:0] F_DEF = 6'b011010;
    localparam logic [5:0] F_MUL = 6'b000001;
    localparam logic [5:0] F_BR  = 6'b111110;
    localparam logic [5:0] F_LU  = 6'b100010;

    logic clk;
    logic rst_n;

    hazard_unit_if #(.CNT_W(CW)) hif ();

    hazard_unit #(.MUL_CYCLES(MULC), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int err_cnt;
    int chk_cnt;
    int occ_q;
    int m_stall;
    int m_flush;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit reads_rs1(input logic [6:0] op);
        logic [6:0] list [5] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
        foreach (list[i]) if (op == list[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        logic [6:0] list [3] = '{7'b0110011, 7'b0100011, 7'b1100011};
        foreach (list[i]) if (op == list[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic mr, input logic [4:0] rd, input logic mult,
                         input logic br, input logic clr);
        hif.id_opcode    = op;
        hif.id_rs1       = rs1;
        hif.id_rs2       = rs2;
        hif.ex_mem_read  = mr;
        hif.ex_rd        = rd;
        hif.ex_is_mult   = mult;
        hif.branch_taken = br;
        hif.clr_stats    = clr;
    endtask

    task automatic do_reset_model();
        occ_q   = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    // Checks one cycle at the falling edge, then advances the model at the rising edge.
    task automatic step(input string tag);
        int         occ;
        logic [5:0] e;
        logic [5:0] got;
        bit         lu;
        bit         st_inc;
        bit         fl_inc;
        @(negedge clk);
        occ    = 0;
        st_inc = 1'b0;
        fl_inc = 1'b0;
        if (!rst_n) begin
            e = F_RST;
        end else begin
            // occ = position of the current cycle inside a mult's EX occupancy
            occ = (occ_q != 0) ? occ_q + 1 : (hif.ex_is_mult ? 1 : 0);
            lu  = hif.ex_mem_read && (hif.ex_rd != 0) &&
                  ((reads_rs1(hif.id_opcode) && hif.ex_rd == hif.id_rs1) ||
                   (reads_rs2(hif.id_opcode) && hif.ex_rd == hif.id_rs2));
            if (occ >= 1 && occ < MULC)      e = F_MUL;
            else if (occ == MULC)            e = F_DEF;
            else if (hif.branch_taken) begin e = F_BR; fl_inc = 1'b1; end
            else if (lu)                     e = F_LU;
            else                             e = F_DEF;
            st_inc = (e[4] == 1'b0);
        end
        got = {hif.ctrl_src, hif.pc_write, hif.if_id_write,
               hif.if_id_flush, hif.id_ex_write, hif.ex_mem_bubble};
        check({tag, ":ctl"},   32'(got), 32'(e));
        check({tag, ":stall"}, 32'(hif.stall_cycles), 32'(m_stall));
        check({tag, ":flush"}, 32'(hif.flush_count),  32'(m_flush));
        $display("[%0t] %s ctl=%b stall=%0d flush=%0d", $time, tag, got,
                 hif.stall_cycles, hif.flush_count);
        @(posedge clk);
        if (rst_n) begin
            occ_q = (occ == MULC) ? 0 : occ;
            if (hif.clr_stats) begin
                m_stall = 0;
                m_flush = 0;
            end else begin
                if (st_inc && m_stall < CMAX) m_stall++;
                if (fl_inc && m_flush < CMAX) m_flush++;
            end
        end
        #1;
    endtask

    initial begin
        logic [6:0] ops [7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                               7'b1100011, 7'b1101111, 7'b0110111};
        err_cnt = 0;
        chk_cnt = 0;
        do_reset_model();
        rst_n = 1'b0;
        drive(7'b0010011, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("reset");
        step("reset");
        rst_n = 1'b1;
        step("idle");

        // Load-use: one bubble then defaults
        drive(7'b0010011, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        step("lu");
        drive(7'b0010011, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("lu_after");

        // No false hazards
        drive(7'b0110011, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step("rd0");
        drive(7'b0010011, 5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        step("addi_rs2");
        drive(7'b0110011, 5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        step("r_rs2");
        drive(7'b0010011, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("idle");

        // Single mult, then two back-to-back
        drive(7'b0110011, 5'd1, 5'd2, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < MULC; i++) step("mul1");
        for (int i = 0; i < 2 * MULC; i++) step("mul2");
        drive(7'b0010011, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("mul_done");

        // Branch with coincident load-use
        drive(7'b0010011, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0);
        step("br_lu");
        drive(7'b0010011, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("br_after");

        // Reset during the second mult stall cycle
        drive(7'b0110011, 5'd1, 5'd2, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        step("rmul");
        rst_n = 1'b0;
        do_reset_model();
        step("rmul_rst");
        step("rmul_rst");
        drive(7'b0010011, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step("rmul_rel");

        // Saturation then clear while stalling
        drive(7'b0010011, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < CMAX + 3; i++) step("sat");
        hif.clr_stats = 1'b1;
        step("sat_clr");
        hif.clr_stats = 1'b0;
        step("sat_post");

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                do_reset_model();
            end else begin
                rst_n = 1'b1;
            end
            drive(ops[$urandom_range(0, 6)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 49) == 0));
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
